// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and glyph table for seven-segment display consumers
//
// Purpose: scan FSM state encoding, blank cathode pattern and the chess-coordinate
// glyph table (values 0..7 show ranks 1..8, values 8..F show files A..H).
// Ports: none (package).
package ssd_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } ssd_state_e;

    // All segments and the decimal point off (cathodes are active-low).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Segment patterns {a,b,c,d,e,f,g}, 0 = lit, indexed by display value.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b1001000,  // F -> H
        7'b0100001,  // E -> G
        7'b0111000,  // D -> F
        7'b0110000,  // C -> E
        7'b1000010,  // B -> d
        7'b0110001,  // A -> C
        7'b1100000,  // 9 -> b
        7'b0001000,  // 8 -> A
        7'b0000000,  // 7 -> 8
        7'b0001111,  // 6 -> 7
        7'b0100000,  // 5 -> 6
        7'b0100100,  // 4 -> 5
        7'b1001100,  // 3 -> 4
        7'b0000110,  // 2 -> 3
        7'b0010010,  // 1 -> 2
        7'b1001111   // 0 -> 1
    };

    // Full cathode byte {Ca..Cg, Dp}; the decimal point is active-low as well.
    function automatic logic [7:0] glyph_cathodes(input logic [3:0] value, input logic dp);
        return {GLYPH_TABLE[value], ~dp};
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// rtl/ssd_glyph_decode.sv - combinational value-to-cathode decoder
//
// Purpose: maps a 4-bit display value and a decimal-point flag to the
// active-low cathode byte using the shared glyph table.
// Ports:
//   value     in  4  display value 0..F
//   dp        in  1  decimal point lit
//   cathodes  out 8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] cathodes
);

    always_comb begin
        cathodes = glyph_cathodes(value, dp);
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - time-multiplexed scan scheduler for an eight-digit display
//
// Purpose: grants the shared cathode bus to one digit per slot, with an
// all-off gap before each slot; display contents are loaded into shadow
// registers and committed to the active set only at frame boundaries.
// Ports:
//   ClkPort     in  1           system clock
//   Reset       in  1           asynchronous, active-high reset
//   load        in  1           capture request, accepted when load & load_ready
//   load_ready  out 1           shadow registers free
//   digit_data  in  4*N_DIGITS  nibble i = value for digit i
//   digit_en    in  N_DIGITS    bit i = digit i lit
//   dp_en       in  N_DIGITS    bit i = decimal point i lit
//   anodes      out N_DIGITS    active-low anodes, registered
//   cathodes    out 8           {Ca..Cg,Dp}, active-low, registered
//   scan_idx    out 3           digit index of the current slot
//   frame_tick  out 1           pulse on the last cycle of the last digit's slot
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int DWELL_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic                  ClkPort,
    input  logic                  Reset,
    input  logic                  load,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] digit_data,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_en,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [7:0]            cathodes,
    output logic [2:0]            scan_idx,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(N_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'(BLANK);
    localparam logic [0:0] ST_SHOW  = 1'(SHOW);

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;

    logic [4*N_DIGITS-1:0] active_data;
    logic [N_DIGITS-1:0]   active_en;
    logic [N_DIGITS-1:0]   active_dp;
    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_en;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  pending;

    logic                  slot_end;
    logic                  frame_end;
    logic                  load_accept;

    logic [3:0]            sel_data;
    logic                  sel_en;
    logic                  sel_dp;
    logic                  show_lit;
    logic [7:0]            glyph;
    logic [N_DIGITS-1:0]   anodes_next;
    logic [7:0]            cathodes_next;

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    always_comb begin
        slot_end  = (state == ST_BLANK) ? (cnt == BLANK_LAST) : (cnt == DWELL_LAST);
        frame_end = (state == ST_SHOW) && (cnt == DWELL_LAST) && (scan_idx == IDX_LAST);
    end

    // Decoded from registers so it is already low during and right after reset.
    assign frame_tick = frame_end;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            scan_idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            if (state == ST_BLANK) begin
                state <= ST_SHOW;
            end else begin
                state    <= ST_BLANK;
                scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Load handshake and frame-boundary commit
    // ------------------------------------------------------------------
    // A load is only accepted while nothing is pending, so an accept and a
    // commit can never coincide; a load taken on the frame_tick cycle waits a
    // whole frame because the commit looks at pending as it stood before it.
    assign load_ready  = ~pending;
    assign load_accept = load & load_ready;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            shadow_data <= '0;
            shadow_en   <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_en   <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            if (load_accept) begin
                shadow_data <= digit_data;
                shadow_en   <= digit_en;
                shadow_dp   <= dp_en;
                pending     <= 1'b1;
            end else if (frame_end && pending) begin
                active_data <= shadow_data;
                active_en   <= shadow_en;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    // Explicit compare-select keeps the 3-bit scan index from over-indexing
    // the narrower per-digit vectors when N_DIGITS < 8.
    always_comb begin
        sel_data = 4'h0;
        sel_en   = 1'b0;
        sel_dp   = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (scan_idx == 3'(i)) begin
                sel_data = active_data[4*i +: 4];
                sel_en   = active_en[i];
                sel_dp   = active_dp[i];
            end
        end
    end

    ssd_glyph_decode u_glyph_decode (
        .value    (sel_data),
        .dp       (sel_dp),
        .cathodes (glyph)
    );

    // A disabled digit keeps its slot dark rather than being skipped, so
    // every enabled digit gets the same duty cycle.
    always_comb begin
        show_lit      = (state == ST_SHOW) && sel_en;
        cathodes_next = show_lit ? glyph : SEG_OFF;
        anodes_next   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            anodes_next[i] = ~(show_lit && (scan_idx == 3'(i)));
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            anodes   <= '1;
            cathodes <= SEG_OFF;
        end else begin
            anodes   <= anodes_next;
            cathodes <= cathodes_next;
        end
    end

endmodule
